iter_multdiv_unit: RTL and testbench

- Parametrised, tagged, iterative signed multiply/divide unit that feeds the execute stage of the pipelined processor.
- Successor of the fixed 32-bit multdiv: operand width is generic, a destination tag travels with each operation, and it adds a valid/ready handshake on both sides, flush, divide-by-zero and overflow exceptions, and a back-to-back issue path.
- The processor holds the pipeline (stalls) while in_ready=0, and writes out_result to register out_tag when out_valid & out_ready.

---
 rtl/iter_multdiv_unit.sv | 165 ++++++++++++++++
 tb/tb_iter_multdiv_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_multdiv_unit.sv
// iter_multdiv_unit: tagged iterative signed multiply/divide for the execute stage.
// Works on operand magnitudes, one multiplier/quotient bit per clock. The sign
// fixup is folded into the last iteration edge.
// Optional build macro MD_EARLY_TERM_EN: multiply leaves RUN as soon as the
// remaining multiplier-magnitude bits are all zero. Divide timing is unaffected.
//
// state | meaning
// IDLE  | waiting for a request
// RUN   | iterating, one bit per edge
// DONE  | result held until the consumer takes it
module iter_multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_exception,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic               op_q, neg_q, valid_q, busy_q, exc_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2*WIDTH-1:0] a_q, acc_q;
  logic [WIDTH-1:0]   b_q, res_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   a_mag_d, b_mag_d;
  logic [2*WIDTH-1:0] shifted_d, acc_d, a_d, prod_d;
  logic [WIDTH:0]     diff_d, hi_d;
  logic [WIDTH-1:0]   b_d, quo_d, res_d;
  logic               exc_d, early_d, last_d, accept;

  assign a_mag_d = in_a[WIDTH-1] ? -in_a : in_a;
  assign b_mag_d = in_b[WIDTH-1] ? -in_b : in_b;

  // Multiply is done when no set multiplier bits remain beyond the one being processed.
`ifdef MD_EARLY_TERM_EN
  assign early_d = ~op_q & ~|b_q[WIDTH-1:1];
`else
  assign early_d = 1'b0;
`endif

  assign last_d   = (cnt_q == CNT_LAST) | early_d;
  assign in_ready = reset & ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // One iteration step plus the signed result/exception that step would produce if it were last.
  always_comb begin
    shifted_d = {acc_q[2*WIDTH-2:0], 1'b0};
    diff_d    = {1'b0, shifted_d[2*WIDTH-1:WIDTH]} - {1'b0, b_q};
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    if (op_q) begin
      // restoring division: keep the trial subtraction only when it does not borrow
      acc_d = diff_d[WIDTH] ? shifted_d : {diff_d[WIDTH-1:0], shifted_d[WIDTH-1:1], 1'b1};
    end else begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      a_d   = {a_q[2*WIDTH-2:0], 1'b0};
      b_d   = {1'b0, b_q[WIDTH-1:1]};
    end
    prod_d = neg_q ? -acc_d : acc_d;
    quo_d  = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    hi_d   = prod_d[2*WIDTH-1:WIDTH-1];
    if (op_q) begin
      res_d = quo_d;
      // only MIN_INT / -1 yields a positive quotient magnitude of 2^(WIDTH-1)
      exc_d = ~neg_q & acc_d[WIDTH-1];
    end else begin
      res_d = prod_d[WIDTH-1:0];
      exc_d = ~((&hi_d) | ~(|hi_d));
    end
  end

  // Control FSM with registered outputs; flush overrides everything except reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      exc_q   <= 1'b0;
      tag_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      op_q  <= in_op;
      neg_q <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
      tag_q <= in_tag;
      a_q   <= {{WIDTH{1'b0}}, a_mag_d};
      b_q   <= b_mag_d;
      acc_q <= in_op ? {{WIDTH{1'b0}}, a_mag_d} : '0;
      cnt_q <= '0;
      if (in_op && (in_b == '0)) begin
        state_q <= S_DONE;
        valid_q <= 1'b1;
        busy_q  <= 1'b0;
        res_q   <= '0;
        exc_q   <= 1'b1;
      end else begin
        state_q <= S_RUN;
        valid_q <= 1'b0;
        busy_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          acc_q <= acc_d;
          a_q   <= a_d;
          b_q   <= b_d;
          if (last_d) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            res_q   <= res_d;
            exc_q   <= exc_d;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid     = valid_q;
  assign out_result    = res_q;
  assign out_exception = exc_q;
  assign out_tag       = tag_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_iter_multdiv_unit.sv
// Directed bench for iter_multdiv_unit (WIDTH=32). Latency is counted in rising
// edges with the accept edge as edge 1.
module tb_iter_multdiv_unit;
  localparam int W = 32;
  localparam int T = 5;
  localparam int LAT_DIV = 33;
`ifdef MD_EARLY_TERM_EN
  localparam int LAT_M_7X3   = 3;
  localparam int LAT_M_BIG   = 18;
  localparam int LAT_M_MIN   = 2;
  localparam int LAT_M_6X7   = 4;
`else
  localparam int LAT_M_7X3   = 33;
  localparam int LAT_M_BIG   = 33;
  localparam int LAT_M_MIN   = 33;
  localparam int LAT_M_6X7   = 33;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_op = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [T-1:0] in_tag = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, out_exception, busy;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  iter_multdiv_unit #(.WIDTH(W), .TAG_W(T)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_exception(out_exception), .out_tag(out_tag), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [T-1:0] tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
  endtask

  // Called #1 after the accept edge; returns edges-to-valid (accept edge = 1).
  task automatic wait_result(output int lat, output logic saw_busy, output logic overlap);
    lat = 1;
    saw_busy = busy;
    overlap = busy & out_valid;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (busy) saw_busy = 1'b1;
      if (busy && out_valid) overlap = 1'b1;
    end
  endtask

  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [T-1:0] tag, output int lat, output logic saw_busy,
                        output logic overlap);
    drive(op, a, b, tag);
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_a = '1; in_b = '1; in_tag = '1; in_op = ~op;
    wait_result(lat, saw_busy, overlap);
  endtask

  task automatic consume();
    @(posedge clock); #1;
    chk1("consumed_valid_low", out_valid, 1'b0);
  endtask

  int           lat;
  logic         sb, ov, rose;
  logic [W-1:0] held;

  initial begin
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_result", out_result, 32'h0);
    chk1("rst_exc", out_exception, 1'b0);
    chkw("rst_tag", W'(out_tag), 32'h0);
    chk1("rst_busy", busy, 1'b0);
    @(negedge clock); reset = 1'b1;
    #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;

    // mult 7 * -3
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd9, lat, sb, ov);
    chki("mul7x3_lat", lat, LAT_M_7X3);
    chkw("mul7x3_res", out_result, 32'hFFFF_FFEB);
    chk1("mul7x3_exc", out_exception, 1'b0);
    chkw("mul7x3_tag", W'(out_tag), 32'd9);
    chk1("mul7x3_overlap", ov, 1'b0);
    consume();

    // div -100 / 7
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd3, lat, sb, ov);
    chki("div100_lat", lat, LAT_DIV);
    chkw("div100_res", out_result, 32'hFFFF_FFF2);
    chk1("div100_exc", out_exception, 1'b0);
    chkw("div100_tag", W'(out_tag), 32'd3);
    consume();

    // div MIN_INT / -1
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, lat, sb, ov);
    chki("divmin_lat", lat, LAT_DIV);
    chkw("divmin_res", out_result, 32'h8000_0000);
    chk1("divmin_exc", out_exception, 1'b1);
    consume();

    // div 5 / 0
    run_op(1'b1, 32'd5, 32'd0, 5'd7, lat, sb, ov);
    chki("div0_lat", lat, 1);
    chkw("div0_res", out_result, 32'h0);
    chk1("div0_exc", out_exception, 1'b1);
    chkw("div0_tag", W'(out_tag), 32'd7);
    chk1("div0_busy", sb, 1'b0);
    consume();

    // mult 0x10000 * 0x10000 overflows
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd2, lat, sb, ov);
    chki("mulbig_lat", lat, LAT_M_BIG);
    chkw("mulbig_res", out_result, 32'h0);
    chk1("mulbig_exc", out_exception, 1'b1);
    consume();

    // mult MIN_INT * -1 overflows, low bits stay MIN_INT
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, lat, sb, ov);
    chki("mulmin_lat", lat, LAT_M_MIN);
    chkw("mulmin_res", out_result, 32'h8000_0000);
    chk1("mulmin_exc", out_exception, 1'b1);
    consume();

    // div -7 / 2 truncates toward zero
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, sb, ov);
    chkw("divneg7_res", out_result, 32'hFFFF_FFFD);
    chk1("divneg7_exc", out_exception, 1'b0);
    consume();

    // held result, then back-to-back issue on the consume edge
    out_ready = 1'b0;
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 5'd11, lat, sb, ov);
    chki("hold_lat", lat, LAT_DIV);
    held = out_result;
    chkw("hold_first_res", held, 32'hFFFF_FFF2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk1("hold_valid", out_valid, 1'b1);
      chkw("hold_res", out_result, 32'hFFFF_FFF2);
      chkw("hold_tag", W'(out_tag), 32'd11);
      chk1("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    drive(1'b0, 32'd6, 32'd7, 5'd12);
    #1;
    chk1("b2b_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk1("b2b_valid_dropped", out_valid, 1'b0);
    chk1("b2b_busy", busy, 1'b1);
    wait_result(lat, sb, ov);
    chki("b2b_lat", lat, LAT_M_6X7);
    chkw("b2b_res", out_result, 32'd42);
    chkw("b2b_tag", W'(out_tag), 32'd12);
    chk1("b2b_exc", out_exception, 1'b0);
    consume();

    // flush during RUN cycle 10 of a divide
    drive(1'b1, 32'd1000, 32'd3, 5'd5);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    flush = 1'b1;
    #1;
    chk1("flush_in_ready_low", in_ready, 1'b0);
    @(posedge clock); #1;
    flush = 1'b0;
    #1;
    chk1("flush_in_ready", in_ready, 1'b1);
    chk1("flush_busy", busy, 1'b0);
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (out_valid) rose = 1'b1;
    end
    chk1("flush_no_valid", rose, 1'b0);

    // async reset mid-RUN
    drive(1'b0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    #1;
    reset = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_valid", out_valid, 1'b0);
    chkw("arst_res", out_result, 32'h0);
    chkw("arst_tag", W'(out_tag), 32'h0);
    chk1("arst_in_ready", in_ready, 1'b0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // normal op after reset
    run_op(1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 5'd8, lat, sb, ov);
    chkw("post_arst_mul_res", out_result, 32'd30);
    chk1("post_arst_mul_exc", out_exception, 1'b0);
    chkw("post_arst_mul_tag", W'(out_tag), 32'd8);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
